// File: rtl/l2_arbiter.sv
// Shares the single L2 port between I-cache and D-cache misses; whole-line transactions, one at a time.
// Grant registers request one cycle after it is seen in IDLE; resp is combinational from l2_resp.
// Losing requester holds its request until served; `ARB_RR_EN selects round-robin, else D-cache wins ties.
module l2_arbiter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_read,
   input  logic [15:0]  i_address,
   output logic         i_resp,
   output logic [127:0] i_rdata,
   input  logic         d_read,
   input  logic         d_write,
   input  logic [15:0]  d_address,
   input  logic [127:0] d_wdata,
   output logic         d_resp,
   output logic [127:0] d_rdata,
   output logic         l2_read,
   output logic         l2_write,
   output logic [15:0]  l2_address,
   output logic [127:0] l2_wdata,
   input  logic         l2_resp,
   input  logic [127:0] l2_rdata
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;

   logic [1:0] state;
   logic       i_req;
   logic       d_req;
   logic       grant_i;
   logic       grant_d;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

`ifdef ARB_RR_EN
   // Set when the D-cache won the last grant; reset value makes the I-cache win the first tie.
   logic last_grant_d;

   always_comb begin
      grant_i = i_req & (~d_req | last_grant_d);
      grant_d = d_req & ~grant_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_d <= 1'b1;
      end else if (state == IDLE && (grant_i || grant_d)) begin
         last_grant_d <= grant_d;
      end
   end
`else
   always_comb begin
      grant_d = d_req;
      grant_i = i_req & ~d_req;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         l2_read    <= 1'b0;
         l2_write   <= 1'b0;
         l2_address <= 16'h0;
         l2_wdata   <= 128'h0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_i) begin
                  state      <= SERVE_I;
                  l2_read    <= 1'b1;
                  l2_write   <= 1'b0;
                  l2_address <= i_address;
                  l2_wdata   <= 128'h0;
               end else if (grant_d) begin
                  // A simultaneous read+write is resolved as a writeback.
                  state      <= SERVE_D;
                  l2_read    <= d_read & ~d_write;
                  l2_write   <= d_write;
                  l2_address <= d_address;
                  l2_wdata   <= d_wdata;
               end
            end
            SERVE_I, SERVE_D: begin
               // Dropping the request for one cycle lets the level-sensitive L2 return to idle.
               if (l2_resp) begin
                  state      <= IDLE;
                  l2_read    <= 1'b0;
                  l2_write   <= 1'b0;
                  l2_address <= 16'h0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign i_resp  = (state == SERVE_I) & l2_resp;
   assign d_resp  = (state == SERVE_D) & l2_resp;
   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;

   a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed vector table, contention sequence, and randomized run against a transaction model.
module tb_l2_arbiter;

`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   localparam logic [15:0]  A  = 16'h1230;
   localparam logic [15:0]  DA = 16'h4440;
   localparam logic [127:0] WD = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] RD = {16{8'hA5}};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_read, d_read, d_write, l2_resp;
   logic [15:0]  i_address, d_address;
   logic [127:0] d_wdata, l2_rdata;
   logic         i_resp, d_resp, l2_read, l2_write;
   logic [127:0] i_rdata, d_rdata, l2_wdata;
   logic [15:0]  l2_address;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   l2_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
      .l2_resp(l2_resp), .l2_rdata(l2_rdata)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      bit           rst_n, ir, dr, dw;
      logic [15:0]  ia, da;
      bit           resp, chk, e_rd, e_wr;
      logic [15:0]  e_addr;
      bit           wd_care;
      logic [127:0] e_wd;
      bit           e_ir, e_dr;
   } vec_t;

   function automatic vec_t mk(bit r, bit ir, bit dr, bit dw, logic [15:0] ia, logic [15:0] da, bit resp,
                               bit c, bit e_rd, bit e_wr, logic [15:0] e_addr, bit wd_care,
                               logic [127:0] e_wd, bit e_ir, bit e_dr);
      vec_t v;
      v.rst_n = r; v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.resp = resp;
      v.chk = c; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.wd_care = wd_care;
      v.e_wd = e_wd; v.e_ir = e_ir; v.e_dr = e_dr;
      return v;
   endfunction

   // 1 = I-cache, 2 = D-cache
   function automatic int pick(bit ip, bit dp, bit i_next);
      if (ip && !dp) return 1;
      if (dp && !ip) return 2;
      return (RR && i_next) ? 1 : 2;
   endfunction

   task automatic drive_idle();
      i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
      i_address = 0; d_address = 0; d_wdata = WD; l2_rdata = RD;
   endtask

   vec_t tbl[$];

   // Winner and loser of the post-reset tie
   logic [15:0]  w_a, l_a;
   logic [127:0] w_wd, l_wd;

   // Random-run model state
   int           owner, cnt, win;
   bit           i_pend, d_pend, i_next, d_wr, rsp;
   logic [15:0]  i_ah, d_ah, cap_addr;
   logic [127:0] d_wdh, cap_wd;
   bit           cap_wr;

   initial begin
      rst_n = 0;
      drive_idle();
      w_a  = RR ? A : DA;   w_wd = RR ? 128'h0 : WD;
      l_a  = RR ? DA : A;   l_wd = RR ? WD : 128'h0;

      tbl.push_back(mk(0,0,0,0,0,0,0, 0, 0,0,0,   0,0,  0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 1, 0,0,0,   1,0,  0,0));
      tbl.push_back(mk(1,1,0,0,A,0,0, 1, 0,0,0,   1,0,  0,0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(1,1,0,0,A,0,0, 1, 1,0,A, 1,0, 0,0));
      tbl.push_back(mk(1,1,0,0,A,0,1, 1, 1,0,A,   1,0,  1,0));
      tbl.push_back(mk(1,0,0,0,0,0,0, 1, 0,0,0,   0,0,  0,0));
      tbl.push_back(mk(1,0,0,1,0,DA,0,1, 0,0,0,   0,0,  0,0));
      tbl.push_back(mk(1,0,0,1,0,DA,0,1, 0,1,DA,  1,WD, 0,0));
      tbl.push_back(mk(1,0,0,1,0,DA,1,1, 0,1,DA,  1,WD, 0,1));
      tbl.push_back(mk(1,0,0,0,0,0,0, 1, 0,0,0,   0,0,  0,0));
      tbl.push_back(mk(1,0,0,0,0,0,1, 1, 0,0,0,   0,0,  0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 1, 0,0,0,   0,0,  0,0));
      tbl.push_back(mk(1,1,1,0,A,DA,0,1, 0,0,0,   1,0,  0,0));
      tbl.push_back(mk(1,1,1,0,A,DA,0,1, 1,0,w_a, 1,w_wd, 0,0));
      tbl.push_back(mk(1,1,1,0,A,DA,1,1, 1,0,w_a, 1,w_wd, RR,!RR));
      tbl.push_back(mk(1,!RR,RR,0,A,DA,0,1, 0,0,0,   0,0,  0,0));
      tbl.push_back(mk(1,!RR,RR,0,A,DA,0,1, 1,0,l_a, 1,l_wd, 0,0));
      tbl.push_back(mk(1,!RR,RR,0,A,DA,1,1, 1,0,l_a, 1,l_wd, !RR,RR));
      tbl.push_back(mk(1,0,0,0,0,0,0, 1, 0,0,0,   0,0,  0,0));
      tbl.push_back(mk(1,0,1,0,0,DA,0,1, 0,0,0,   0,0,  0,0));
      tbl.push_back(mk(0,0,1,0,0,DA,0,1, 1,0,DA,  1,WD, 0,0));
      tbl.push_back(mk(1,0,0,0,0,0,1, 1, 0,0,0,   1,0,  0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0, 1, 0,0,0,   1,0,  0,0));

      foreach (tbl[n]) begin
         @(posedge clk); #1;
         rst_n = tbl[n].rst_n; i_read = tbl[n].ir; d_read = tbl[n].dr; d_write = tbl[n].dw;
         i_address = tbl[n].ia; d_address = tbl[n].da; l2_resp = tbl[n].resp;
         @(negedge clk);
         if (tbl[n].chk) begin
            chk($sformatf("v%0d l2_read", n), l2_read, tbl[n].e_rd);
            chk($sformatf("v%0d l2_write", n), l2_write, tbl[n].e_wr);
            chk($sformatf("v%0d l2_address", n), l2_address, tbl[n].e_addr);
            chk($sformatf("v%0d i_resp", n), i_resp, tbl[n].e_ir);
            chk($sformatf("v%0d d_resp", n), d_resp, tbl[n].e_dr);
            if (tbl[n].wd_care) chk($sformatf("v%0d l2_wdata", n), l2_wdata, tbl[n].e_wd);
            if (tbl[n].e_ir) chk($sformatf("v%0d i_rdata", n), i_rdata, RD);
            if (tbl[n].e_dr) chk($sformatf("v%0d d_rdata", n), d_rdata, RD);
         end
      end

      // Continuous contention: both sides keep requesting, L2 answers one cycle after each grant.
      @(posedge clk); #1; drive_idle(); rst_n = 0;
      @(posedge clk); #1; rst_n = 1; i_read = 1; d_read = 1; i_address = A; d_address = DA;
      for (int t = 0; t < 6; t++) begin
         bit to_i;
         to_i = RR ? (t % 2 == 0) : 1'b0;
         @(posedge clk); #1; l2_resp = 0;
         @(negedge clk);
         chk($sformatf("cont%0d grant", t), l2_read, 1'b1);
         chk($sformatf("cont%0d addr", t), l2_address, to_i ? A : DA);
         @(posedge clk); #1; l2_resp = 1;
         @(negedge clk);
         chk($sformatf("cont%0d i_resp", t), i_resp, to_i);
         chk($sformatf("cont%0d d_resp", t), d_resp, !to_i);
         @(posedge clk); #1; l2_resp = 0;
         @(negedge clk);
         chk($sformatf("cont%0d gap", t), l2_read | l2_write, 1'b0);
      end

      // Randomized run against a transaction-level model.
      @(posedge clk); #1; drive_idle(); rst_n = 0;
      owner = 0; cnt = 0; i_pend = 0; d_pend = 0; i_next = 1;
      i_ah = 0; d_ah = 0; d_wr = 0; d_wdh = 0; cap_addr = 0; cap_wd = 0; cap_wr = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rst_n = 1;
         if (!i_pend && $urandom_range(0, 3) == 0) begin
            i_pend = 1; i_ah = 16'($urandom);
         end
         if (!d_pend && $urandom_range(0, 3) == 0) begin
            d_pend = 1; d_ah = 16'($urandom); d_wr = 1'($urandom_range(0, 1));
            d_wdh = {$urandom, $urandom, $urandom, $urandom};
         end
         i_read = i_pend; i_address = i_pend ? i_ah : 16'($urandom);
         d_read = d_pend && !d_wr; d_write = d_pend && d_wr;
         d_address = d_pend ? d_ah : 16'($urandom);
         d_wdata = d_pend ? d_wdh : {$urandom, $urandom, $urandom, $urandom};
         if (owner != 0) begin
            rsp = (cnt == 0);
            if (!rsp) cnt--;
         end else begin
            rsp = ($urandom_range(0, 9) == 0);
         end
         l2_resp = rsp;
         l2_rdata = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         chk("rnd l2_read", l2_read, owner == 1 || (owner == 2 && !cap_wr));
         chk("rnd l2_write", l2_write, owner == 2 && cap_wr);
         chk("rnd l2_address", l2_address, owner != 0 ? cap_addr : 16'h0);
         if (owner != 0) chk("rnd l2_wdata", l2_wdata, cap_wd);
         chk("rnd i_resp", i_resp, owner == 1 && rsp);
         chk("rnd d_resp", d_resp, owner == 2 && rsp);
         if (owner == 1 && rsp) chk("rnd i_rdata", i_rdata, l2_rdata);
         if (owner == 2 && rsp) chk("rnd d_rdata", d_rdata, l2_rdata);
         if (owner != 0) begin
            if (rsp) begin
               if (owner == 1) i_pend = 0; else d_pend = 0;
               owner = 0;
            end
         end else if (i_pend || d_pend) begin
            win = pick(i_pend, d_pend, i_next);
            owner = win;
            i_next = (win == 2);
            cnt = $urandom_range(0, 3);
            cap_addr = (win == 1) ? i_ah : d_ah;
            cap_wd = (win == 1) ? 128'h0 : d_wdh;
            cap_wr = (win == 2) && d_wr;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
